// File: rtl/i2s_tx_frame.sv
// i2s_tx_frame: I2S / left-justified stereo transmitter with a one-entry sample buffer.
// Generates sck and ws from clk, shifts samples MSB first into SLOT_W-bit slots.
// Optional build macro: I2S_TX_REPEAT_EN - on underrun, resend the previous frame's words
// instead of zeros (the underrun pulse is still raised).
module i2s_tx_frame #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int SCK_DIV  = 44
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fmt,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                sck,
    output logic                ws,
    output logic                din,
    output logic                underrun
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_W      = $clog2(SCK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_next;
    logic [SAMPLE_W-1:0] word_l;
    logic [SAMPLE_W-1:0] word_r;
    logic [SAMPLE_W-1:0] buf_l;
    logic [SAMPLE_W-1:0] buf_r;
    logic                buf_full;
    logic                dly;
    logic                dly_next;
    logic                div_last;
    logic                fall_evt;
    logic                boundary;
    logic                take;
    logic [SAMPLE_W-1:0] fill_l;
    logic [SAMPLE_W-1:0] fill_r;
    logic [SAMPLE_W-1:0] word_l_next;
    logic [SAMPLE_W-1:0] word_r_next;
    logic                din_next;

    // Serial bit for a given bit counter position and delay: slot position p selects the
    // channel and the bit within the slot; bits beyond the sample width are padded with 0.
    function automatic logic serial_bit(input logic [SAMPLE_W-1:0] lw,
                                        input logic [SAMPLE_W-1:0] rw,
                                        input logic [BIT_W-1:0]    bc,
                                        input logic                dl);
        int p;
        int j;
        logic [SAMPLE_W-1:0] w;
        logic [SAMPLE_W-1:0] sh;
        p = int'(bc) - (dl ? 1 : 0);
        if (p < 0) p = p + FRAME_BITS;
        if (p < SLOT_W) begin
            w = lw;
            j = p;
        end else begin
            w = rw;
            j = p - SLOT_W;
        end
        if (j < SAMPLE_W) begin
            sh = w >> (SAMPLE_W - 1 - j);
            return sh[0];
        end
        return 1'b0;
    endfunction

    // What gets loaded when a frame starts with an empty buffer.
`ifdef I2S_TX_REPEAT_EN
    assign fill_l = word_l;
    assign fill_r = word_r;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    assign div_last = (div_cnt == DIV_W'(SCK_DIV - 1));
    assign fall_evt = div_last && sck;
    assign take     = in_valid && !buf_full;
    assign in_ready = !buf_full;

    // Next bit position, frame-boundary detection and the data bit to present next.
    // At an I2S boundary the outgoing bit is the last bit of the old right word, so it
    // is taken from the words before they are replaced.
    always_comb begin
        bit_next    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
        boundary    = fall_evt && (bit_cnt == BIT_W'(FRAME_BITS - 1));
        dly_next    = boundary ? !fmt : dly;
        word_l_next = word_l;
        word_r_next = word_r;
        if (boundary) begin
            word_l_next = buf_full ? buf_l : fill_l;
            word_r_next = buf_full ? buf_r : fill_r;
        end
        if (boundary && !fmt)
            din_next = serial_bit(word_l, word_r, '0, 1'b1);
        else
            din_next = serial_bit(word_l_next, word_r_next, bit_next, dly_next);
    end

    // Bit clock divider: sck toggles each time the counter reaches SCK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (div_last) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serial side: advance bit position, ws and din on sck falling; load words at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= BIT_W'(FRAME_BITS - 1);
            ws       <= 1'b0;
            din      <= 1'b0;
            dly      <= 1'b1;
            word_l   <= '0;
            word_r   <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= boundary && !buf_full;
            if (fall_evt) begin
                bit_cnt <= bit_next;
                ws      <= (bit_next >= BIT_W'(SLOT_W));
                din     <= din_next;
                dly     <= dly_next;
                word_l  <= word_l_next;
                word_r  <= word_r_next;
            end
        end
    end

    // One-entry holding buffer: filled by a handshake, emptied by the frame-start load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_l    <= '0;
            buf_r    <= '0;
            buf_full <= 1'b0;
        end else if (take) begin
            buf_l    <= in_left;
            buf_r    <= in_right;
            buf_full <= 1'b1;
        end else if (boundary) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_frame.sv
// tb_i2s_tx_frame: directed checks of i2s_tx_frame (16/16 slot and 16/24 slot builds, SCK_DIV=4).
module tb_i2s_tx_frame;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst24_n;
    logic        fmt;
    logic        in_valid;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_ready, sck, ws, din, underrun;
    logic        in_ready24, sck24, ws24, din24, underrun24;
    logic        sel;
    logic        holdValid;
    logic [15:0] nextL, nextR;
    int          assertCount = 0;
    int          failCount = 0;

    wire sckM      = sel ? sck24      : sck;
    wire wsM       = sel ? ws24       : ws;
    wire dinM      = sel ? din24      : din;
    wire underrunM = sel ? underrun24 : underrun;
    wire readyM    = sel ? in_ready24 : in_ready;

    i2s_tx_frame #(.SAMPLE_W(16), .SLOT_W(16), .SCK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .fmt(fmt), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .sck(sck), .ws(ws), .din(din),
        .underrun(underrun));

    i2s_tx_frame #(.SAMPLE_W(16), .SLOT_W(24), .SCK_DIV(4)) u_dut24 (
        .clk(clk), .rst_n(rst24_n), .fmt(fmt), .in_valid(in_valid), .in_ready(in_ready24),
        .in_left(in_left), .in_right(in_right), .sck(sck24), .ws(ws24), .din(din24),
        .underrun(underrun24));

    always #5 clk = ~clk;

    // Reference bit: position p = bit - delay, left slot then right slot, MSB first, zero pad.
    function automatic logic expBit(input logic [15:0] l, input logic [15:0] r, input logic tail,
                                    input int slot, input logic lj, input int b);
        int p;
        int j;
        logic [15:0] w;
        logic [15:0] sh;
        p = lj ? b : b - 1;
        if (p < 0) return tail;
        if (p < slot) begin
            w = l;
            j = p;
        end else begin
            w = r;
            j = p - slot;
        end
        if (j >= 16) return 1'b0;
        sh = w >> (15 - j);
        return sh[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitFall(output logic found);
        logic prev;
        found = 1'b0;
        prev  = sckM;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (prev && !sckM) begin
                found = 1'b1;
                break;
            end
            prev = sckM;
        end
    endtask

    // Walks one frame from its boundary, checking ws/din per bit; at bit 5 applies fmt and
    // optional new sample pair, at bit 6 drops a one-shot in_valid.
    task automatic applyStimulus(input string tag, input logic [15:0] l, input logic [15:0] r,
                                 input logic tail, input int slot, input logic lj,
                                 input logic expU, input int nbits, input logic newFmt,
                                 input logic sendEn, input logic [15:0] sL,
                                 input logic [15:0] sR, input logic startHold);
        logic ok;
        waitFall(ok);
        checkOutput({tag, "_fall0"}, 32'(ok), 32'd1);
        checkOutput({tag, "_underrun"}, 32'(underrunM), 32'(expU));
        checkOutput({tag, "_ws0"}, 32'(wsM), 32'd0);
        checkOutput({tag, "_din0"}, 32'(dinM), 32'(expBit(l, r, tail, slot, lj, 0)));
        checkOutput({tag, "_ready_bnd"}, 32'(readyM), 32'd1);
        if (holdValid) begin
            in_left  = nextL;
            in_right = nextR;
        end
        @(negedge clk);
        checkOutput({tag, "_underrun_end"}, 32'(underrunM), 32'd0);
        if (holdValid) checkOutput({tag, "_ready_low"}, 32'(readyM), 32'd0);
        for (int b = 1; b < nbits; b++) begin
            waitFall(ok);
            checkOutput($sformatf("%s_fall%0d", tag, b), 32'(ok), 32'd1);
            checkOutput($sformatf("%s_ws%0d", tag, b), 32'(wsM), 32'(b >= slot));
            checkOutput($sformatf("%s_din%0d", tag, b), 32'(dinM),
                        32'(expBit(l, r, tail, slot, lj, b)));
            if (b == 5) begin
                fmt = newFmt;
                if (sendEn) begin
                    in_left  = sL;
                    in_right = sR;
                    in_valid = 1'b1;
                end
                if (startHold) holdValid = 1'b1;
            end
            if (b == 6 && sendEn && !holdValid) in_valid = 1'b0;
        end
    endtask

    initial begin
        int  fallAt;
        logic prev;
        sel       = 1'b0;
        holdValid = 1'b0;
        rst_n     = 1'b0;
        rst24_n   = 1'b0;
        fmt       = 1'b0;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        nextL     = 16'hBEEF;
        nextR     = 16'hCAFE;
        repeat (3) @(negedge clk);
        checkOutput("rst_sck", 32'(sck), 32'd0);
        checkOutput("rst_ws", 32'(ws), 32'd0);
        checkOutput("rst_din", 32'(din), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        // I2S frame with A5C3/0F01 loaded before the first boundary.
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_left  = 16'hA5C3;
        in_right = 16'h0F01;
        @(negedge clk);
        checkOutput("xfer_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        applyStimulus("f0", 16'hA5C3, 16'h0F01, 1'b0, 16, 1'b0, 1'b0, 32, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        // Empty buffer: underrun, zeros, tail bit of 0F01; queue LJ frame mid-way.
        applyStimulus("f1", 16'h0000, 16'h0000, 1'b1, 16, 1'b0, 1'b1, 32, 1'b1, 1'b1, 16'h8001, 16'h7FFF, 1'b0);
        // Left-justified frame; fmt back to I2S mid-frame must not disturb it; start holding valid.
        applyStimulus("f2", 16'h8001, 16'h7FFF, 1'b0, 16, 1'b1, 1'b0, 32, 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1);
        applyStimulus("f3", 16'h1234, 16'h5678, 1'b1, 16, 1'b0, 1'b0, 32, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        applyStimulus("f4", 16'hBEEF, 16'hCAFE, 1'b0, 16, 1'b0, 1'b0, 8, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        // Asynchronous reset at bit 7, then the first boundary 8 clk after release.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_sck", 32'(sck), 32'd0);
        checkOutput("arst_ws", 32'(ws), 32'd0);
        checkOutput("arst_din", 32'(din), 32'd0);
        checkOutput("arst_ready", 32'(in_ready), 32'd1);
        holdValid = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        fallAt = 0;
        prev   = sck;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (prev && !sck) begin
                fallAt = k;
                break;
            end
            prev = sck;
        end
        checkOutput("arst_first_fall", 32'(fallAt), 32'd8);
        checkOutput("arst_underrun", 32'(underrun), 32'd1);

        // 24-bit slots, left-justified: 16 data bits then 8 zeros per slot, 48 sck per frame.
        rst_n = 1'b0;
        sel   = 1'b1;
        @(negedge clk);
        rst24_n  = 1'b1;
        fmt      = 1'b1;
        in_valid = 1'b1;
        in_left  = 16'hA5C3;
        in_right = 16'h0F01;
        @(negedge clk);
        checkOutput("s24_ready_low", 32'(in_ready24), 32'd0);
        in_valid = 1'b0;
        applyStimulus("s24a", 16'hA5C3, 16'h0F01, 1'b0, 24, 1'b1, 1'b0, 48, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        applyStimulus("s24b", 16'h0000, 16'h0000, 1'b0, 24, 1'b1, 1'b1, 1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/i2s_tx_frame.md
# i2s_tx_frame

Parametrised I2S transmitter for the audio output path. It generates the bit clock and word select from the system clock, serialises stereo samples into configurable slot widths in Philips I2S or left-justified format, and takes samples through a valid/ready handshake with a one-entry holding buffer. It sits between the sample source (mixer/DSP) and the DAC pins.

## Interface
- `SAMPLE_W`, 16: sample width per channel, 8..32.
- `SLOT_W`, 16: bits per channel slot; must be ≥ `SAMPLE_W`, ≤ 32.
- `SCK_DIV`, 44: `clk` cycles per half-period of `sck`; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fmt`  in  1  format: 0 = I2S (1-bit delay), 1 = left-justified; sampled at frame boundary.
- `in_valid`  in  1  sample pair valid.
- `in_ready`  out  1  buffer empty, can accept.
- `in_left`  in  `SAMPLE_W`  left sample, two's complement.
- `in_right`  in  `SAMPLE_W`  right sample.
- `sck`  out  1  bit clock.
- `ws`  out  1  word select: 0 = left, 1 = right.
- `din`  out  1  serial data to DAC.
- `underrun`  out  1  one-`clk` pulse: frame started with buffer empty.

## Operation
- Divider counts 0..`SCK_DIV`-1; `sck` toggles on the cycle the count equals `SCK_DIV`-1, then wraps to 0. `sck` period = 2·`SCK_DIV` clk.
- "Fall event" = the clk cycle in which `sck` goes 1→0. `bit_cnt`, `ws`, `din` update only on fall events, so the DAC samples stable data on `sck` rising.
- `bit_cnt` runs 0..2·`SLOT_W`-1 and wraps. Frame boundary = fall event where `bit_cnt` wraps to 0.
- `ws` = 1 when `bit_cnt` ≥ `SLOT_W`, else 0.
- Delay d = 1 (I2S) or 0 (LJ), latched at frame boundary. Position p = (`bit_cnt` − d) mod 2·`SLOT_W`; channel = left if p < `SLOT_W`; j = p mod `SLOT_W`; `din` = word[`SAMPLE_W`-1-j] if j < `SAMPLE_W`, else 0. MSB first.
- In I2S mode the bit at `bit_cnt`=0 is p = 2·`SLOT_W`-1, belonging to the previous frame's right word; that word is retained until this bit has been sent.
- Handshake: transfer when `in_valid` && `in_ready`; `in_ready` = buffer empty. Accepted data is stable in the buffer; input may change after transfer.
- At frame boundary: buffer full → load left/right shift words, buffer empties. Buffer empty → load zeros and pulse `underrun`; a transfer in the same cycle fills the buffer for the next frame.

## Timing
- Reset values: `sck`=0, `ws`=0, `din`=0, `underrun`=0, `in_ready`=1, divider=0, `bit_cnt`=2·`SLOT_W`-1, shift words and buffer=0, d=1.
- After reset release, `sck` rises at clk cycle `SCK_DIV` and first falls (first frame boundary) at cycle 2·`SCK_DIV`.
- Frame = 2·`SLOT_W`·2·`SCK_DIV` clk cycles.
- `in_ready` falls the cycle after a transfer; rises the cycle after the frame-boundary load.
- `underrun` asserted for exactly the frame-boundary cycle.
- `fmt` change mid-frame has no effect until the next boundary.
- Reset mid-frame: all state returns to reset values immediately; partial frame abandoned, buffer contents discarded.

## Configuration
- `I2S_TX_REPEAT_EN`: defined → on underrun the previous frame's left/right words are reloaded (and `underrun` still pulses). Undefined → zeros loaded as above.

## Test plan
- `SAMPLE_W`=16, `SLOT_W`=16, `SCK_DIV`=4, `fmt`=0, send L=16'hA5C3, R=16'h0F01 before first boundary -> `ws` 0 for 16 sck, 1 for 16; `din` at `bit_cnt` 1..16 = A5C3 MSB-first, 17..31 and next frame bit 0 = 0F01.
- Same words with `fmt`=1 -> A5C3 on `bit_cnt` 0..15, 0F01 on 16..31.
- `SLOT_W`=24, `SAMPLE_W`=16, `fmt`=1 -> 16 data bits then 8 zeros per slot; frame = 48 sck.
- No `in_valid` for one frame -> `underrun` one-cycle pulse at boundary, `din` all zeros (or repeats last frame with `I2S_TX_REPEAT_EN`).
- `in_valid` held high continuously -> `in_ready` low except one cycle after each boundary; no underrun, consecutive samples on consecutive frames.
- `rst_n` low at `bit_cnt`=7 -> outputs at reset values asynchronously; first boundary 2·`SCK_DIV` cycles after release.
